// File: rtl/serial_word_scheduler.sv
// serial_word_scheduler
//   Shares one 32-bit-to-byte serialization path among NUM_REQ word sources.
//   A round-robin arbiter grants one source per word. The granted word is
//   latched and then emitted as 4 bytes on a valid/ready byte stream. The
//   default order is least-significant byte first; MSB_FIRST=1 reverses it.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   SRC_W      width of the source id, clog2(NUM_REQ)
//   MSB_FIRST  1 = emit bits 31:24 first
//
// Ports
//   clock      single clock, all logic on posedge
//   reset      synchronous, active-high
//   req_valid  per-source "word pending"
//   req_data   word of source i at [32*i +: 32]
//   req_ready  one-hot accept, combinational; word i taken on valid&ready edge
//   out_byte   serialized byte
//   out_valid  out_byte valid (equals busy)
//   out_ready  downstream accepts byte when out_valid&out_ready
//   out_last   high with the 4th byte of a word
//   out_src    id of the source owning the current byte
//   busy       a latched word is being serialized
module serial_word_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int SRC_W     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [7:0]              out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [SRC_W-1:0]        out_src,
  output logic                    busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [1:0]       k;
  logic [31:0]      word;
  logic [SRC_W-1:0] last_granted;

  logic             last_hs;
  logic             window;
  logic             grant_found;
  logic             accept;
  logic [SRC_W-1:0] grant_id;
  logic [SRC_W-1:0] cand;
  logic [31:0]      grant_word;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [1:0] pos;
    pos = MSB_FIRST ? (2'd3 - idx) : idx;
    return w[8*pos +: 8];
  endfunction

  // Grant window also opens on the edge the last byte leaves, so words
  // stream back to back without an idle cycle.
  always_comb begin
    last_hs = (state == SEND) && out_valid && out_ready && (k == 2'd3);
    window  = !reset && ((state == IDLE) || last_hs);
  end

  // Round-robin search starting one past the last accepted source.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = SRC_W'((32'(last_granted) + off) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    grant_word = req_data[32*grant_id +: 32];
    accept     = window && grant_found;
    req_ready  = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      word         <= '0;
      last_granted <= SRC_W'(NUM_REQ - 1);
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_byte     <= '0;
      out_src      <= '0;
      busy         <= 1'b0;
    end else if (accept) begin
      state        <= SEND;
      k            <= '0;
      word         <= grant_word;
      last_granted <= grant_id;
      out_valid    <= 1'b1;
      out_last     <= 1'b0;
      out_byte     <= pick_byte(grant_word, 2'd0);
      out_src      <= grant_id;
      busy         <= 1'b1;
    end else if (state == SEND && out_ready) begin
      if (k == 2'd3) begin
        state     <= IDLE;
        k         <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        k        <= k + 2'd1;
        out_byte <= pick_byte(word, k + 2'd1);
        out_last <= (k == 2'd2);
      end
    end
  end

endmodule

// File: tb/tb_serial_word_scheduler.sv
module tb_serial_word_scheduler;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic [1:0]   out_src;
  logic         busy;

  logic [3:0]   m_valid = '0;
  logic [127:0] m_data = '0;
  logic [3:0]   m_ready;
  logic [7:0]   m_byte;
  logic         m_ovalid;
  logic         m_oready = 1'b1;
  logic         m_last;
  logic [1:0]   m_src;
  logic         m_busy;

  always #5 clock = ~clock;

  serial_word_scheduler #(.NUM_REQ(4), .SRC_W(2), .MSB_FIRST(1'b0)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_src(out_src), .busy(busy)
  );

  serial_word_scheduler #(.NUM_REQ(4), .SRC_W(2), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .req_valid(m_valid), .req_data(m_data),
    .req_ready(m_ready), .out_byte(m_byte), .out_valid(m_ovalid),
    .out_ready(m_oready), .out_last(m_last), .out_src(m_src), .busy(m_busy)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [1:0] src;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   remaining = 0;   // bytes of the held word not yet handed off
  int   ptr = 3;         // last granted source
  bit   exp_busy = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // One clock cycle of stimulus; the reference model decides the grant and
  // queues the bytes that grant must produce.
  task automatic drive(input logic [3:0] v, input logic [127:0] d, input logic rdy,
                       input logic rst);
    logic [3:0]  exp_rdy;
    logic [31:0] wd;
    int          w;
    bit          found;
    @(negedge clock);
    reset = rst; req_valid = v; req_data = d; out_ready = rdy;
    #1;
    exp_rdy = '0;
    if (rst) begin
      sb.delete();
      remaining = 0;
      ptr = 3;
      exp_busy = 1'b0;
    end else begin
      exp_busy = (remaining != 0);
      mon_en = 1'b1;
      if ((remaining == 0 || (remaining == 1 && rdy)) && v != 4'd0) begin
        found = 1'b0;
        w = 0;
        for (int o = 1; o <= 4; o++) begin
          if (!found && v[(ptr + o) % 4]) begin
            found = 1'b1;
            w = (ptr + o) % 4;
          end
        end
        exp_rdy[w] = 1'b1;
        wd = d[32*w +: 32];
        for (int j = 0; j < 4; j++)
          sb.push_back('{b: wd[8*j +: 8], last: (j == 3), src: 2'(w)});
        ptr = w;
        remaining = 4;
      end else if (remaining != 0 && rdy) begin
        remaining--;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
  endtask

  // Monitor: compares the presented byte with the scoreboard head every cycle
  // and retires it on handshake, so stalled bytes must stay unchanged.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (mon_en && !reset) begin
        chk("out_valid", 64'(out_valid), 64'(exp_busy));
        chk("busy", 64'(busy), 64'(exp_busy));
        if (out_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got byte %0h expected none at %0t", out_byte, $time);
          end else begin
            e = sb[0];
            chk("out_byte", 64'(out_byte), 64'(e.b));
            chk("out_last", 64'(out_last), 64'(e.last));
            chk("out_src", 64'(out_src), 64'(e.src));
            if (out_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_out_byte", 64'(out_byte), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0]  msb_word;
    logic [7:0]   msb_exp [4];

    drive('0, '0, 1'b1, 1'b1);
    drive('0, '0, 1'b1, 1'b1);
    drive('0, '0, 1'b1, 1'b0);
    chk_reset_vals();

    // Single word from source 0.
    d = '0; d[31:0] = 32'hA1B2_C3D4;
    drive(4'b0001, d, 1'b1, 1'b0);
    repeat (6) drive('0, '0, 1'b1, 1'b0);

    // Round robin with all sources valid.
    repeat (20) drive(4'b1111, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    repeat (6) drive('0, '0, 1'b1, 1'b0);

    // Backpressure during the second byte.
    d = '0; d[63:32] = 32'h1122_3344;
    drive(4'b0010, d, 1'b1, 1'b0);
    drive('0, '0, 1'b1, 1'b0);
    repeat (3) drive('0, '0, 1'b0, 1'b0);
    repeat (5) drive('0, '0, 1'b1, 1'b0);

    // Pointer hold across idle cycles: after src2, src3 beats src1.
    drive(4'b0100, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    repeat (9) drive('0, '0, 1'b1, 1'b0);
    repeat (8) drive(4'b1010, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    repeat (5) drive('0, '0, 1'b1, 1'b0);

    // Reset mid-word, then src0 wins over src2.
    drive(4'b0100, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    drive('0, '0, 1'b1, 1'b0);
    drive('0, '0, 1'b1, 1'b0);
    drive('0, '0, 1'b1, 1'b1);
    drive(4'b0101, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    chk_reset_vals();
    repeat (6) drive('0, '0, 1'b1, 1'b0);

    // Randomized traffic with occasional stalls, dropped requests and resets.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 3 == 0) ? 4'd0 : 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom},
            ($urandom % 4) != 0, ($urandom % 160) == 0);
    end
    repeat (12) drive('0, '0, 1'b1, 1'b0);
    chk("drained", 64'(sb.size()), 64'd0);

    // MSB-first instance.
    msb_word = 32'hDEAD_BEEF;
    msb_exp[0] = 8'hDE; msb_exp[1] = 8'hAD; msb_exp[2] = 8'hBE; msb_exp[3] = 8'hEF;
    drive('0, '0, 1'b1, 1'b0);
    m_oready = 1'b1;
    m_valid = 4'b0001;
    m_data = '0;
    m_data[31:0] = msb_word;
    #1;
    chk("msb_req_ready", 64'(m_ready), 64'd1);
    for (int j = 0; j < 4; j++) begin
      drive('0, '0, 1'b1, 1'b0);
      m_valid = '0;
      chk("msb_valid", 64'(m_ovalid), 64'd1);
      chk("msb_byte", 64'(m_byte), 64'(msb_exp[j]));
      chk("msb_last", 64'(m_last), 64'(j == 3));
      chk("msb_src", 64'(m_src), 64'd0);
    end
    drive('0, '0, 1'b1, 1'b0);
    chk("msb_idle", 64'(m_ovalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
